// File: rtl/minisys_timer.sv
// ---------------------------------------------------------------------------
// minisys_timer
//   Two-channel memory-mapped timer/counter for the minisys I/O window.
//   Each channel has a mode register, an initial-value register and a
//   down-counter. A channel counts either every clk (timer) or each rising
//   edge of its external pulse input (counter). When it expires it raises
//   done and a one-cycle cout pulse, and optionally reloads (repeat mode).
//
// Ports
//   clk    in   system clock; all state updates on posedge clk
//   rst    in   asynchronous active-high reset
//   cs     in   chip select for the timer address window
//   rd     in   read strobe (qualified by cs)
//   wr     in   write strobe (qualified by cs, wins over rd)
//   addr   in   [2:0] halfword offset: 0/2 mode+status, 4/6 init+count
//   wdata  in   [15:0] write data
//   rdata  out  [15:0] registered read data, 1-cycle latency
//   pulse1 in   asynchronous count input, channel 0
//   pulse2 in   asynchronous count input, channel 1
//   cout1  out  one-cycle expiry pulse, channel 0
//   cout2  out  one-cycle expiry pulse, channel 1
// ---------------------------------------------------------------------------
module minisys_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        rd,
    input  logic        wr,
    input  logic [2:0]  addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    input  logic        pulse1,
    input  logic        pulse2,
    output logic        cout1,
    output logic        cout2
);

    localparam int unsigned NCH = 2;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_e;

    // Bus qualification: a simultaneous rd & wr is a write only.
    logic wr_en;
    logic rd_en;

    assign wr_en = cs & wr;
    assign rd_en = cs & rd & ~wr;

    logic [NCH-1:0] pulse_in;
    logic [NCH-1:0] ch_cout;
    logic [15:0]    ch_count  [NCH];
    logic [15:0]    ch_status [NCH];

    assign pulse_in = {pulse2, pulse1};

    // -----------------------------------------------------------------------
    // Channels (identical, fully independent)
    // -----------------------------------------------------------------------
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        localparam logic [2:0] A_MODE = 3'(2 * g);
        localparam logic [2:0] A_INIT = 3'(4 + 2 * g);

        logic [1:0]  mode_q,  mode_d;
        logic [15:0] init_q,  init_d;
        logic [15:0] count_q, count_d;
        ch_state_e   state_q, state_d;
        logic        done_q,  done_d;
        logic        cout_q,  cout_d;
        logic        sync1_q, sync1_d;
        logic        sync2_q, sync2_d;
        logic        edge_q,  edge_d;

        logic mode_wr;
        logic init_wr;
        logic stat_rd;
        logic running;
        logic edge_tick;
        logic tick;
        logic expire;

        always_comb begin
            mode_wr   = wr_en && (addr == A_MODE);
            init_wr   = wr_en && (addr == A_INIT);
            stat_rd   = rd_en && (addr == A_MODE);
            running   = (state_q == CH_RUN);
            edge_tick = sync2_q & ~edge_q;
            tick      = running & (mode_q[0] ? edge_tick : 1'b1);
            // An initial-value write on the same cycle pre-empts the tick.
            expire    = tick & ~init_wr & (count_q == 16'd1);
        end

        always_comb begin
            mode_d  = mode_q;
            init_d  = init_q;
            count_d = count_q;
            state_d = state_q;
            done_d  = done_q;
            cout_d  = 1'b0;
            sync1_d = pulse_in[g];
            sync2_d = sync1_q;
            edge_d  = sync2_q;

            if (init_wr) begin
                init_d  = wdata;
                count_d = wdata;
                state_d = (wdata != 16'd0) ? CH_RUN : CH_IDLE;
            end else if (tick) begin
                if (count_q == 16'd1) begin
                    cout_d = 1'b1;
                    if (mode_q[1]) begin
                        count_d = init_q;
                    end else begin
                        count_d = '0;
                        state_d = CH_IDLE;
                    end
                end else if (count_q != 16'd0) begin
                    count_d = count_q - 16'd1;
                end else begin
                    // Running with a zero count cannot count further.
                    state_d = CH_IDLE;
                end
            end

            // Mode write stops the channel but lets a same-cycle expiry
            // still raise done and cout.
            if (mode_wr) begin
                mode_d  = wdata[1:0];
                state_d = CH_IDLE;
            end

            // Expiry set has priority over the read-clear of done.
            if (stat_rd) begin
                done_d = 1'b0;
            end
            if (expire) begin
                done_d = 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mode_q  <= '0;
                init_q  <= '0;
                count_q <= '0;
                state_q <= CH_IDLE;
                done_q  <= 1'b0;
                cout_q  <= 1'b0;
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                edge_q  <= 1'b0;
            end else begin
                mode_q  <= mode_d;
                init_q  <= init_d;
                count_q <= count_d;
                state_q <= state_d;
                done_q  <= done_d;
                cout_q  <= cout_d;
                sync1_q <= sync1_d;
                sync2_q <= sync2_d;
                edge_q  <= edge_d;
            end
        end

        assign ch_cout[g]   = cout_q;
        assign ch_count[g]  = count_q;
        assign ch_status[g] = {14'b0, running, done_q};
    end

    // -----------------------------------------------------------------------
    // Read data register: holds when there is no read
    // -----------------------------------------------------------------------
    logic [15:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            case (addr)
                3'h0:    rdata_d = ch_status[0];
                3'h2:    rdata_d = ch_status[1];
                3'h4:    rdata_d = ch_count[0];
                3'h6:    rdata_d = ch_count[1];
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
    assign cout1 = ch_cout[0];
    assign cout2 = ch_cout[1];

endmodule

// File: tb/tb_minisys_timer.sv
// ---------------------------------------------------------------------------
// tb_minisys_timer
//   Directed self-checking bench for minisys_timer. Bus operations start and
//   end on a negedge; expected read data is queued when a read is issued and
//   popped when rdata becomes valid on the following negedge.
// ---------------------------------------------------------------------------
module tb_minisys_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs;
    logic        rd;
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        pulse1;
    logic        pulse2;
    logic        cout1;
    logic        cout2;

    int checks   = 0;
    int failures = 0;
    int cout1_cnt = 0;
    int cout2_cnt = 0;

    string       tag_q[$];
    logic [15:0] exp_q[$];

    minisys_timer dut (
        .clk    (clk),
        .rst    (rst),
        .cs     (cs),
        .rd     (rd),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .pulse1 (pulse1),
        .pulse2 (pulse2),
        .cout1  (cout1),
        .cout2  (cout2)
    );

    always #5 clk = ~clk;

    // Count expiry pulses, sampled shortly after each active edge.
    always @(posedge clk) begin
        #2;
        if (cout1 === 1'b1) cout1_cnt++;
        if (cout2 === 1'b1) cout2_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        chk(tag, {15'b0, obs}, {15'b0, exp});
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
        cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; wdata = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] a, input logic [15:0] exp, input string tag);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
        cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        chk(tag_q.pop_front(), rdata, exp_q.pop_front());
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int c0;

    initial begin
        rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0;
        addr = '0; wdata = '0; pulse1 = 1'b0; pulse2 = 1'b0;
        idle(2);
        chk("reset_rdata", rdata, 16'h0000);
        chk_bit("reset_cout1", cout1, 1'b0);
        chk_bit("reset_cout2", cout2, 1'b0);
        rst = 1'b0;
        idle(1);
        bus_rd(3'h0, 16'h0000, "reset_status0");
        bus_rd(3'h6, 16'h0000, "reset_count1");

        // One-shot timer on channel 0
        c0 = cout1_cnt;
        bus_wr(3'h0, 16'h0000);
        bus_wr(3'h4, 16'd3);
        bus_rd(3'h4, 16'd3, "os_count3");
        chk_bit("os_cout_lo_a", cout1, 1'b0);
        bus_rd(3'h4, 16'd2, "os_count2");
        chk_bit("os_cout_lo_b", cout1, 1'b0);
        bus_rd(3'h4, 16'd1, "os_count1");
        chk_bit("os_cout_hi", cout1, 1'b1);
        bus_rd(3'h0, 16'h0001, "os_status_done");
        chk_bit("os_cout_lo_c", cout1, 1'b0);
        bus_rd(3'h0, 16'h0000, "os_status_clr");
        bus_rd(3'h4, 16'h0000, "os_count_idle");
        chk("os_pulses", 16'(cout1_cnt - c0), 16'd1);

        // Repeat timer on channel 1
        bus_wr(3'h2, 16'h0002);
        bus_wr(3'h6, 16'd2);
        for (int k = 1; k <= 8; k++) begin
            idle(1);
            chk_bit("rep_cout2", cout2, (k % 2) == 0);
        end
        bus_rd(3'h2, 16'h0003, "rep_status");
        chk_bit("rep_cout2_lo", cout2, 1'b0);
        // This mode write lands on an expiry cycle.
        bus_wr(3'h2, 16'h0000);
        chk_bit("rep_stop_cout2", cout2, 1'b1);
        bus_rd(3'h2, 16'h0001, "rep_stop_status");
        c0 = cout2_cnt;
        idle(6);
        chk("rep_stopped", 16'(cout2_cnt - c0), 16'd0);
        bus_rd(3'h2, 16'h0000, "rep_status_clr");

        // Counter mode on channel 0
        bus_wr(3'h0, 16'h0001);
        bus_wr(3'h4, 16'd4);
        idle(5);
        bus_rd(3'h4, 16'd4, "cnt_hold4");
        for (int k = 1; k <= 3; k++) begin
            pulse1 = 1'b1;
            idle(2);
            pulse1 = 1'b0;
            idle(2);
            bus_rd(3'h4, 16'(4 - k), "cnt_edge");
        end
        pulse1 = 1'b1;
        idle(1);
        chk_bit("cnt_cout_e1", cout1, 1'b0);
        idle(1);
        chk_bit("cnt_cout_e2", cout1, 1'b0);
        pulse1 = 1'b0;
        idle(1);
        chk_bit("cnt_cout_e3", cout1, 1'b1);
        idle(1);
        chk_bit("cnt_cout_e4", cout1, 1'b0);
        bus_rd(3'h0, 16'h0001, "cnt_status");

        // Initial-value write on the expiry cycle
        c0 = cout1_cnt;
        bus_wr(3'h0, 16'h0000);
        bus_wr(3'h4, 16'd2);
        idle(1);
        bus_wr(3'h4, 16'd5);
        chk_bit("col_init_nocout", cout1, 1'b0);
        bus_rd(3'h4, 16'd5, "col_init_count");
        chk_bit("col_init_nocout2", cout1, 1'b0);
        bus_rd(3'h0, 16'h0002, "col_init_status");
        bus_wr(3'h0, 16'h0000);
        chk("col_init_pulses", 16'(cout1_cnt - c0), 16'd0);

        // Status read on the expiry cycle
        bus_wr(3'h4, 16'd2);
        idle(1);
        bus_rd(3'h0, 16'h0002, "col_rd_old");
        chk_bit("col_rd_cout", cout1, 1'b1);
        bus_rd(3'h0, 16'h0001, "col_rd_done");
        bus_rd(3'h0, 16'h0000, "col_rd_clr");

        // Reset mid-run
        bus_wr(3'h4, 16'd100);
        idle(9);
        bus_rd(3'h4, 16'd91, "rst_mid_count");
        rst = 1'b1;
        #1;
        chk("rst_async_rdata", rdata, 16'h0000);
        chk_bit("rst_async_cout1", cout1, 1'b0);
        idle(2);
        rst = 1'b0;
        c0 = cout1_cnt;
        idle(120);
        chk("rst_no_pulse", 16'(cout1_cnt - c0), 16'd0);
        bus_rd(3'h0, 16'h0000, "rst_status0");
        bus_rd(3'h4, 16'h0000, "rst_count0");
        bus_rd(3'h2, 16'h0000, "rst_status1");

        // rd & wr together, unmapped reads, zero init, cs = 0 write
        bus_wr(3'h6, 16'd50);
        bus_rd(3'h6, 16'd50, "b_count1");
        cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 3'h4; wdata = 16'd6;
        idle(1);
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
        chk("rdwr_hold", rdata, 16'd50);
        bus_rd(3'h4, 16'd6, "rdwr_write");
        bus_rd(3'h7, 16'h0000, "unmapped7");
        bus_rd(3'h6, 16'd46, "b_count1_run");
        bus_rd(3'h5, 16'h0000, "unmapped5");

        c0 = cout1_cnt;
        bus_wr(3'h0, 16'h0000);
        bus_wr(3'h4, 16'h0000);
        idle(5);
        bus_rd(3'h0, 16'h0000, "init0_zero_status");
        bus_rd(3'h4, 16'h0000, "init0_zero_count");
        chk("init0_zero_pulses", 16'(cout1_cnt - c0), 16'd0);

        cs = 1'b0; wr = 1'b1; addr = 3'h4; wdata = 16'd9;
        idle(1);
        wr = 1'b0;
        bus_rd(3'h4, 16'h0000, "cs0_write_count");
        bus_rd(3'h0, 16'h0000, "cs0_write_status");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/minisys_timer.md
MINISYS_TIMER -- requirements
Module: minisys_timer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock (divided clock used by the pipeline); all logic rises on posedge clk.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: cs  in  1  chip select, decoded by the MEM stage from the timer I/O address window.
REQ-004 SHALL have ports: rd  in  1  read strobe, qualified by cs.
REQ-005 SHALL have ports: wr  in  1  write strobe, qualified by cs.
REQ-006 SHALL have ports: addr  in  3  halfword offset within the window.
REQ-007 SHALL have ports: wdata  in  16  write data, taken from write_dataM[15:0].
REQ-008 SHALL have ports: rdata  out  16  registered read data returned to the MEM stage.
REQ-009 SHALL have ports: pulse1, pulse2  in  1 each  external count inputs for channels 0 and 1; these are asynchronous.
REQ-010 SHALL have ports: cout1, cout2  out  1 each  one-cycle expiry pulses for channels 0 and 1.

Function
REQ-011 The address map SHALL be:
- 0x0: ch0 mode on write, ch0 status on read.
- 0x2: ch1 mode on write, ch1 status on read.
- 0x4: ch0 initial value on write, ch0 current count on read.
- 0x6: ch1 initial value on write, ch1 current count on read.
- Other offsets: writes are ignored and reads return 0x0000.
REQ-012 The mode register SHALL be 2 bits:
- bit0 = 0: timer, counts every clk.
- bit0 = 1: counter, counts rising edges of the channel's pulse input.
- bit1 = 1: auto-reload (repeat).
REQ-013 A mode write SHALL stop the channel (running = 0) and SHALL leave the count and the initial value unchanged.
REQ-014 An initial-value write of N != 0 SHALL load both the initial register and the count with N and SHALL set running = 1 from the next cycle.
REQ-015 An initial-value write of N = 0 SHALL store 0, clear running and never set done.
REQ-016 Each pulse input SHALL pass through a 2-flop synchroniser and then a rising-edge detector; a tick is one cycle wide.
REQ-017 A tick SHALL be clk while running in timer mode, or a detected edge while running in counter mode.
REQ-018 On a tick with count > 1, the count SHALL decrement by 1.
REQ-019 On a tick with count == 1, the channel SHALL:
- set done = 1;
- assert its cout for exactly the next cycle;
- reload the count to the initial value and stay running if repeat = 1;
- otherwise set count = 0 and running = 0.
REQ-020 Status SHALL read as {14'b0, running, done}.
REQ-021 A status read SHALL clear done in the cycle after the read.
REQ-022 If expiry and a status read occur in the same cycle, done SHALL remain 1: the set wins and the read returns the old value.
REQ-023 An initial-value write coinciding with a tick SHALL win: the count = the new N, there is no decrement and no expiry.
REQ-024 A mode write coinciding with an expiry SHALL stop the channel, while done and cout SHALL still assert.
REQ-025 rdata SHALL update on the clk edge that samples cs & rd, giving 1-cycle read latency.
REQ-026 rdata SHALL hold its value when there is no read.
REQ-027 The count reflected in rdata SHALL be the pre-edge value.
REQ-028 A write with cs = 0 SHALL have no effect, and rd & wr asserted together SHALL be treated as a write only.
REQ-029 Count arithmetic SHALL be unsigned 16-bit with no wrap below 0; count 0 with running = 0 is idle.
REQ-030 Both channels SHALL be fully independent and identical.

Reset
REQ-031 On rst = 1, regardless of clk, the block SHALL clear to 0:
- mode, initial value and count of both channels;
- running and done;
- synchroniser and edge-detect flops;
- rdata;
- cout1 and cout2.
REQ-032 Reset asserted mid-count SHALL abort the count with no cout pulse; after release, both channels SHALL be idle until an initial-value write.

Verification
REQ-033 One-shot timer: write mode0 = 0b00, then init0 = 3 -> count reads 3, 2, 1 on successive cycles; cout1 high for one cycle; status0 reads 0x0001; a second status read returns 0x0000.
REQ-034 Repeat timer: mode1 = 0b10, init1 = 2 -> cout2 pulses every 2 cycles continuously; status1 reads 0x0003.
REQ-035 Counter mode: mode0 = 0b01, init0 = 4, then apply 4 pulse1 rising edges spaced 5 cycles apart -> cout1 fires 3 cycles after the 4th edge (2-flop sync + edge detect), and count stays 4 with no pulses.
REQ-036 Collisions:
- init0 = 5 written on the expiry cycle of a running count -> count = 5, no cout1.
- Status read on the expiry cycle -> done still 1 afterwards.
REQ-037 Reset mid-run: init0 = 100, assert rst after 10 cycles -> all registers 0 immediately, cout1 never pulses, and status0 reads 0x0000 after release.
REQ-038 Unmapped/boundary: a read at offset 0x7 -> 0x0000; init0 = 0 -> status0 stays 0x0000 and cout1 stays low.
